// File: rtl/loadable_down_timer_pkg.sv
// Shared definitions for the counter library: timer FSM encoding and mode codes.
package loadable_down_timer_pkg;

    // Two-state timer FSM, 1-bit encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Mode codes sampled on a load.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/loadable_down_timer.sv
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// A load always wins over counting; the terminal count is a registered pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | stopped; count holds; en ignored; waits for a non-zero load
// ST_RUN  | counting down on en; terminal count at count==1 -> tc pulse
module loadable_down_timer
    import loadable_down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;

    // Next-state and datapath decode: ld > en > hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (ld_i) begin
            // A zero load latches the registers but leaves the timer stopped.
            count_d  = load_value_i;
            reload_d = load_value_i;
            mode_d   = mode_i;
            state_d  = (load_value_i != ZERO) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && en_i) begin
            if (count_q == ONE) begin
                tc_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    // Reload directly so a periodic timer never shows 0.
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = ST_IDLE;
                end
            end else if (count_q != ZERO) begin
                count_d = count_q - ONE;
            end else begin
                // Unreachable in normal operation; park rather than wrap.
                state_d = ST_IDLE;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            mode_q   <= MODE_ONESHOT;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == ST_RUN);
    assign tc_o    = tc_q;

endmodule

// File: doc/loadable_down_timer.md
Name: loadable_down_timer

Overview:
- Loadable down-counting timer: the count-down counterpart of the team's loadable up-counter.
- Software or a controller loads a start value. The block decrements on each enabled cycle and flags the terminal count with a one-cycle pulse.
- Supports one-shot mode (stop at zero) and periodic mode (auto-reload).
- Used as the interval/timeout generator next to the up-counters in the counter library.

Parameters:
- WIDTH, 8, bit width of the load value, count and reload register.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ld  input  1  load strobe; latches load_value and mode, (re)starts the timer.
- en  input  1  count enable; one decrement per cycle while high and running.
- mode  input  1  sampled only when ld=1; 0 = one-shot, 1 = periodic.
- load_value  input  WIDTH  start/reload value, sampled only when ld=1.
- count  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN state, registered.
- tc  output  1  terminal-count pulse, exactly one cycle wide, registered.

Behaviour:
- Reset (async, rst=1): count=0, tc=0, busy=0, reload_reg=0, mode_reg=0, state=IDLE. Applies immediately, including mid-run.
- State IDLE:
  - busy=0; count holds its value; en is ignored.
  - ld=1, load_value!=0: count<=load_value, reload_reg<=load_value, mode_reg<=mode, go to RUN.
  - ld=1, load_value==0: count<=0, registers latched, stay in IDLE, no tc.
- State RUN (busy=1):
  - Priority is ld > en > hold.
  - ld=1: same as a load from IDLE. This restarts the timer and takes effect even when en=1 and count==1; no tc in that cycle.
  - ld=0, en=1, count>1: count<=count-1, tc<=0.
  - ld=0, en=1, count==1, mode_reg=0 (one-shot): count<=0, tc<=1, go to IDLE. busy drops in the same cycle tc rises.
  - ld=0, en=1, count==1, mode_reg=1 (periodic): count<=reload_reg, tc<=1, stay in RUN. count never shows 0 in periodic mode.
  - en=0: count holds, tc<=0.
- Latency: one cycle from a sampled ld or en to the updated count, busy and tc.
- tc is 0 in every cycle not listed above. It never stays high two cycles in a row, except periodic reload_reg==1 with en held, where tc stays high continuously (one pulse per decrement event).
- Arithmetic: unsigned, WIDTH bits. The count never decrements below 0; there is no wrap-around. A maximum load of 2^WIDTH-1 is legal.
- The mode and load_value inputs are don't-care when ld=0.

Decomposition:
- Shared counter package holds:
  - state enum {IDLE, RUN}, encoded in 1 bit;
  - MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1 constants.
- Single module: a 2-state FSM plus a count/reload datapath. No sub-module is warranted.
- The existing up-counter is not reused, because its priority and terminal logic differ.

Test Plan:
1. Assert rst for 2 cycles, then release; load 5 one-shot with en=1; assert rst again while count==3 -> count=0, busy=0, tc=0 immediately; no tc afterwards.
2. One-shot: ld with load_value=3, mode=0, then en=1 held -> count 3,2,1,0 on successive cycles. tc=1 only in the cycle count becomes 0, busy falls in that same cycle, and count stays 0 afterwards.
3. Periodic: ld with load_value=2, mode=1, en=1 held for 6 cycles -> count 2,1,2,1,2,1. tc=1 on each 1->2 reload, busy stays 1.
4. Enable gaps: load 4 one-shot, en pattern 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0 and exactly one tc, at the final step.
5. Zero load: ld with load_value=0 from IDLE and then from RUN -> count=0, busy=0, no tc pulse.
6. Reload priority: in RUN with count==1, apply ld=1 (load_value=7) together with en=1 -> count=7, tc=0, busy=1; the decrement resumes the next cycle.
